// File: rtl/over_pkg.sv
// rtl/over_pkg.sv - shared types and constants for the game-over overlay
package over_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REVEAL,
    ST_SHOW,
    ST_EXIT
  } over_state_t;

  // Default banner geometry on a 640x480 screen
  localparam int DEF_IMG_W    = 256;
  localparam int DEF_IMG_H    = 64;
  localparam int DEF_ORIGIN_X = 192;
  localparam int DEF_ORIGIN_Y = 208;
  localparam int DEF_ADDR_W   = 14;

  // Frame-based animation timing
  localparam int DEF_WIPE_STEP    = 4;
  localparam int DEF_BLINK_FRAMES = 30;

  // Palette index 0 never overrides the background
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

endpackage

// File: rtl/over_frame_timer.sv
// rtl/over_frame_timer.sv - frame-counted blink phase generator for the banner
module over_frame_timer
  import over_pkg::*;
#(
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start,
  input  logic clear,
  input  logic enable,
  output logic blink_on
);

  localparam int              CNT_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             on_q;

  // Clear restarts a visible half-period; each enabled frame advances the count
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      on_q  <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else if (enable && frame_start) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        on_q  <= ~on_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign blink_on = on_q;

endmodule

// File: rtl/over_screen_ctrl.sv
// rtl/over_screen_ctrl.sv - game-over overlay sequencer and sprite pixel pipeline
module over_screen_ctrl
  import over_pkg::*;
#(
  parameter int IMG_W        = DEF_IMG_W,
  parameter int IMG_H        = DEF_IMG_H,
  parameter int ORIGIN_X     = DEF_ORIGIN_X,
  parameter int ORIGIN_Y     = DEF_ORIGIN_Y,
  parameter int WIPE_STEP    = DEF_WIPE_STEP,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              game_over,
  input  logic              restart_req,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  output logic              overlay_valid,
  output logic              restart_ack
);

  localparam int         XB   = $clog2(IMG_W);
  localparam logic [10:0] X0   = 11'(ORIGIN_X);
  localparam logic [10:0] X1   = 11'(ORIGIN_X + IMG_W);
  localparam logic [10:0] Y0   = 11'(ORIGIN_Y);
  localparam logic [10:0] Y1   = 11'(ORIGIN_Y + IMG_H);
  localparam logic [10:0] ROWS = 11'(IMG_H);
  localparam logic [10:0] STEP = 11'(WIPE_STEP);

  over_state_t state_q;
  logic [10:0] reveal_q;
  logic [10:0] reveal_d;
  logic        ack_q;
  logic        flag_q;
  logic        flag_d;
  logic        blink_on;
  logic        timer_clear;
  logic        timer_en;
  logic [9:0]  rel_x;
  logic [9:0]  rel_y;
  logic        hit;
  logic        visible;

  // Next wipe height, saturating at the full sprite height
  always_comb begin
    reveal_d = reveal_q + STEP;
    if (reveal_d > ROWS) begin
      reveal_d = ROWS;
    end
  end

  // Overlay sequencer; reveal height is zeroed whenever the overlay goes idle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      reveal_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start && game_over) begin
            state_q  <= ST_REVEAL;
            reveal_q <= '0;
          end
        end
        ST_REVEAL: begin
          if (frame_start) begin
            if (!game_over) begin
              state_q  <= ST_IDLE;
              reveal_q <= '0;
            end else if (reveal_q == ROWS) begin
              state_q <= ST_SHOW;
            end else begin
              reveal_q <= reveal_d;
            end
          end
        end
        ST_SHOW: begin
          if (restart_req) begin
            state_q <= ST_EXIT;
          end else if (frame_start && !game_over) begin
            state_q  <= ST_IDLE;
            reveal_q <= '0;
          end
        end
        ST_EXIT: begin
          if (frame_start) begin
            state_q  <= ST_IDLE;
            reveal_q <= '0;
            ack_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          reveal_q <= '0;
        end
      endcase
    end
  end

  // A restart in the same cycle as frame_start suppresses the blink step
  assign timer_clear = (state_q == ST_REVEAL) && frame_start && game_over && (reveal_q == ROWS);
  assign timer_en    = (state_q == ST_SHOW) && !restart_req;

  over_frame_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .clear      (timer_clear),
    .enable     (timer_en),
    .blink_on   (blink_on)
  );

  // Stage 0: box hit test limited to the rows revealed so far
  assign rel_x = DrawX - 10'(ORIGIN_X);
  assign rel_y = DrawY - 10'(ORIGIN_Y);
  assign hit   = ({1'b0, DrawX} >= X0) && ({1'b0, DrawX} < X1) &&
                 ({1'b0, DrawY} >= Y0) && ({1'b0, DrawY} < Y1) &&
                 ({1'b0, rel_y} < reveal_q);

  assign rom_addr = hit ? ((ADDR_W'(rel_y) << XB) + ADDR_W'(rel_x)) : '0;

  assign visible = (state_q == ST_REVEAL) || ((state_q == ST_SHOW) && blink_on);
  assign flag_d  = hit && visible;

  // Stage 1: align the draw decision with the synchronous ROM read
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign pal_index     = flag_q ? rom_data : TRANSPARENT_IDX;
  assign overlay_valid = flag_q && (rom_data != TRANSPARENT_IDX);
  assign restart_ack   = ack_q;

endmodule

// File: tb/tb_over_screen_ctrl.sv
// tb/tb_over_screen_ctrl.sv - directed self-checking bench for over_screen_ctrl
module tb_over_screen_ctrl;

  logic        Clk;
  logic        Reset;
  logic        frame_start;
  logic        game_over;
  logic        restart_req;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pal_index;
  logic        overlay_valid;
  logic        restart_ack;

  int checks;
  int errors;

  typedef struct {
    int x;
    int y;
    int d;
    int addr;
    int pal;
    int vld;
  } vec_t;

  vec_t full_vecs[8];

  over_screen_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_start  (frame_start),
    .game_over    (game_over),
    .restart_req  (restart_req),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pal_index    (pal_index),
    .overlay_valid(overlay_valid),
    .restart_ack  (restart_ack)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Present a pixel, then supply the ROM word one cycle later as a sync ROM would
  task automatic pix(input string nm, input int x, input int y, input int d,
                     input int ea, input int ep, input int ev);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    chk({nm, "_addr"}, int'(rom_addr), ea);
    tick();
    rom_data = 4'(d);
    DrawX    = '0;
    DrawY    = '0;
    #1;
    chk({nm, "_pal"}, int'(pal_index), ep);
    chk({nm, "_vld"}, int'(overlay_valid), ev);
    rom_data = '0;
    tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    Reset       = 1'b1;
    frame_start = 1'b0;
    game_over   = 1'b0;
    restart_req = 1'b0;
    DrawX       = 10'd192;
    DrawY       = 10'd208;
    rom_data    = 4'd5;

    full_vecs[0] = '{192, 208,  5,     0,  5, 1};
    full_vecs[1] = '{447, 271,  7, 16383,  7, 1};
    full_vecs[2] = '{191, 208,  5,     0,  0, 0};
    full_vecs[3] = '{448, 208,  5,     0,  0, 0};
    full_vecs[4] = '{300, 207,  5,     0,  0, 0};
    full_vecs[5] = '{300, 272,  5,     0,  0, 0};
    full_vecs[6] = '{193, 208,  0,     1,  0, 0};
    full_vecs[7] = '{300, 230, 15,  5740, 15, 1};

    tick();
    tick();
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_pal", int'(pal_index), 0);
    chk("rst_vld", int'(overlay_valid), 0);
    chk("rst_ack", int'(restart_ack), 0);
    Reset    = 1'b0;
    rom_data = '0;
    tick();

    // Enter REVEAL with nothing revealed yet
    game_over = 1'b1;
    frame();
    pix("rev0", 192, 208, 5, 0, 0, 0);

    // First wipe step exposes rows 0..3
    frame();
    pix("rev4_in", 200, 211, 5, 776, 5, 1);
    pix("rev4_out", 200, 212, 5, 0, 0, 0);
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    pix("rev4_rr", 200, 211, 5, 776, 5, 1);

    // Remaining wipe steps reach the full 64 rows
    frames(15);
    for (int i = 0; i < 8; i++) begin
      pix($sformatf("full%0d", i), full_vecs[i].x, full_vecs[i].y, full_vecs[i].d,
          full_vecs[i].addr, full_vecs[i].pal, full_vecs[i].vld);
    end

    // Into SHOW, then one blink period
    frame();
    pix("show_on", 192, 208, 5, 0, 5, 1);
    frames(29);
    pix("blink29", 193, 209, 5, 257, 5, 1);
    frame();
    pix("blink_off", 193, 209, 5, 257, 0, 0);
    frames(29);
    pix("blink_off2", 193, 209, 5, 257, 0, 0);
    frame();
    pix("blink_on", 193, 209, 5, 257, 5, 1);

    // Restart handshake
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    pix("exit_px", 193, 209, 5, 257, 0, 0);
    chk("exit_ack_pre", int'(restart_ack), 0);
    frame_start = 1'b1;
    #1;
    chk("exit_ack_fs", int'(restart_ack), 0);
    tick();
    frame_start = 1'b0;
    chk("exit_ack_hi", int'(restart_ack), 1);
    tick();
    chk("exit_ack_lo", int'(restart_ack), 0);
    pix("idle_px", 193, 209, 5, 0, 0, 0);

    // Reset in the middle of the wipe at 20 rows
    frame();
    frames(5);
    DrawX    = 10'd200;
    DrawY    = 10'd219;
    rom_data = 4'd5;
    #1;
    chk("mid_addr", int'(rom_addr), 2824);
    tick();
    chk("mid_vld", int'(overlay_valid), 1);
    Reset = 1'b1;
    #1;
    chk("arst_addr", int'(rom_addr), 0);
    chk("arst_pal", int'(pal_index), 0);
    chk("arst_vld", int'(overlay_valid), 0);
    chk("arst_ack", int'(restart_ack), 0);
    tick();
    Reset     = 1'b0;
    rom_data  = '0;
    game_over = 1'b0;
    tick();
    frames(2);
    pix("held_idle", 200, 211, 5, 0, 0, 0);
    game_over = 1'b1;
    frame();
    pix("rerev0", 200, 211, 5, 0, 0, 0);
    frame();
    pix("rerev4", 200, 211, 5, 776, 5, 1);

    // Dropping game_over aborts without an ack
    game_over = 1'b0;
    frame();
    chk("abort_ack", int'(restart_ack), 0);
    pix("abort_px", 200, 211, 5, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/over_screen_ctrl.md
# over_screen_ctrl

Sequencer for the game-over overlay. It tracks game state at frame boundaries, reveals the banner sprite with a top-down wipe, then blinks it until the player restarts. It generates sprite ROM addresses from the VGA scan position and emits a 4-bit palette index plus a valid flag, one cycle behind DrawX/DrawY. It sits between the VGA controller and the colour mapper; the 4-bit index feeds the game-over palette lookup.

## Interface
Parameters:
- IMG_W, 256, sprite width in pixels (power of two)
- IMG_H, 64, sprite height in pixels
- ORIGIN_X, 192, left edge of sprite on screen
- ORIGIN_Y, 208, top edge of sprite on screen
- WIPE_STEP, 4, rows revealed per frame
- BLINK_FRAMES, 30, frames per blink half-period
- ADDR_W, 14, ROM address width; IMG_W*IMG_H ≤ 2^ADDR_W

Ports:
- Clk  in  1  pixel-domain clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of each frame
- game_over  in  1  level from game logic
- restart_req  in  1  one-cycle pulse from the keyboard decoder
- DrawX  in  10  current scan column
- DrawY  in  10  current scan row
- rom_addr  out  ADDR_W  sprite ROM address; combinational from DrawX/DrawY
- rom_data  in  4  sprite ROM index, valid 1 cycle after rom_addr
- pal_index  out  4  palette index for the colour mapper
- overlay_valid  out  1  high when pal_index overrides the background
- restart_ack  out  1  one-cycle pulse when the overlay exits

## Operation
- States: IDLE, REVEAL, SHOW, EXIT. Transitions are evaluated only on cycles where frame_start=1, except restart_req.
- IDLE → REVEAL when game_over=1 at frame_start. reveal_rows is cleared to 0.
- REVEAL: at each frame_start, reveal_rows += WIPE_STEP, saturating at IMG_H. At a frame_start where reveal_rows==IMG_H before the increment, go to SHOW with blink_cnt=0 and blink_on=1. restart_req is ignored.
- SHOW: at each frame_start, blink_cnt increments. When blink_cnt==BLINK_FRAMES-1, it wraps to 0 and blink_on toggles. restart_req=1 in any cycle → EXIT.
- EXIT: at the next frame_start → IDLE, with restart_ack=1 for exactly that cycle.
- In REVEAL or SHOW, game_over=0 at frame_start → IDLE. No ack is issued in this case.
- If restart_req and frame_start occur in the same SHOW cycle, the state goes to EXIT and blink_cnt is not updated.
- Hit test (stage 0): rel_x=DrawX-ORIGIN_X, rel_y=DrawY-ORIGIN_Y, both unsigned 10-bit. hit = DrawX in [ORIGIN_X, ORIGIN_X+IMG_W), DrawY in [ORIGIN_Y, ORIGIN_Y+IMG_H), and rel_y < reveal_rows.
- rom_addr = rel_y*IMG_W + rel_x, truncated to ADDR_W. rom_addr = 0 when hit=0.
- Visibility: visible = (state==REVEAL) or (state==SHOW and blink_on).
- Stage 1 registers hit&visible. pal_index = rom_data when the registered flag is 1, else 0. overlay_valid = registered flag and rom_data≠0; index 0 is transparent.

## Timing
- Reset values: state=IDLE, reveal_rows=0, blink_cnt=0, blink_on=0, pipeline flag=0.
- Reset output values: pal_index=0, overlay_valid=0, restart_ack=0. rom_addr=0 because hit=0 in IDLE.
- Pixel latency is 1 cycle, from DrawX/DrawY to pal_index/overlay_valid, matching the sync ROM.
- State changes take effect in the cycle after frame_start. A frame is therefore never split between reveal heights or blink phases.
- Asserting Reset mid-frame forces all outputs to 0 immediately, with no ack.

## Structure
- over_pkg holds:
  - the state enum typedef (over_state_t)
  - the default geometry constants and timing constants
  - the transparent-index constant (4'h0)
- One sub-module, over_frame_timer, handles the blink counter and toggle. Its inputs are frame_start, clear and enable; its output is blink_on.
- The top level contains the FSM, wipe counter and pixel pipeline.

## Test plan
- Reset, then game_over=1 and a frame_start pulse → state REVEAL, reveal_rows=0. After 16 further frame_starts → reveal_rows=64. The next frame_start → SHOW.
- In SHOW: DrawX=192, DrawY=208, rom_data=5 → next cycle rom_addr=0, pal_index=5, overlay_valid=1. DrawX=447, DrawY=271 → rom_addr=16383.
- Out-of-box and transparent pixels: DrawX=191 or DrawX=448 → rom_addr=0, pal_index=0, overlay_valid=0. rom_data=0 in-box → overlay_valid=0.
- Blink in SHOW: after 30 frame_starts blink_on=0 and in-box pixels are invalid. After 30 more, pixels are valid again.
- restart_req in SHOW → EXIT. At the next frame_start, restart_ack is high for exactly 1 cycle, then IDLE. restart_req during REVEAL → no state change.
- Reset asserted mid-REVEAL at reveal_rows=20 → all outputs 0 at once. After release, IDLE is held until game_over=1 at a frame_start.
